// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int MAX_LOAD_LAT = 15;
    localparam int REM_W        = 4;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_src_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hazard_src_cmp
// Description : Single-source dependency compare against the EX destination.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_cmp #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic              i_rs_used,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_match
);

    // x0 is hard-wired zero, so a write to it can never create a dependency
    assign o_match = i_rs_used && (i_rs_addr == i_rd_addr) && (i_rd_addr != '0);

endmodule : hazard_src_cmp
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : ID/EX hazard controller: load-use stall, memory freeze, flush.
//               Optional HAZARD_PERF_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         rd_addr_ex_i,
    input  logic                      mem_read_ex_i,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_id_i,
    input  logic [NUM_SRC-1:0]        rs_used_id_i,
    input  logic                      branch_taken_id_i,
    input  logic                      mem_stall_i,
    output logic                      pc_write_o,
    output logic                      stall_o,
    output logic                      noop_o,
    output logic                      flush_o,
    output logic                      freeze_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               load_stall_cnt_o,
    output logic [31:0]               flush_cnt_o
`endif
);

    localparam bit               c_multi    = (LOAD_LAT > 1);
    localparam logic [REM_W-1:0] c_rem_init = REM_W'(LOAD_LAT - 1);

    state_t           r_state;
    logic [REM_W-1:0] r_rem;
    logic [NUM_SRC-1:0] w_src_hit;
    logic             w_hit;
    logic             w_load_stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_cmp #(
            .ADDR_W (ADDR_W)
        ) u_cmp (
            .i_rs_addr (rs_addr_id_i[k*ADDR_W +: ADDR_W]),
            .i_rs_used (rs_used_id_i[k]),
            .i_rd_addr (rd_addr_ex_i),
            .o_match   (w_src_hit[k])
        );
    end

    assign w_hit        = mem_read_ex_i && (|w_src_hit);
    // While counting down, the producing load has already left EX, so a hit is irrelevant
    assign w_load_stall = (r_state == LOAD_STALL) || w_hit;

    always_comb begin
        pc_write_o = 1'b1;
        stall_o    = 1'b0;
        noop_o     = 1'b0;
        flush_o    = 1'b0;
        freeze_o   = 1'b0;
        if (!rst_i) begin
            if (mem_stall_i) begin
                freeze_o   = 1'b1;
                pc_write_o = 1'b0;
                stall_o    = 1'b1;
            end else if (w_load_stall) begin
                pc_write_o = 1'b0;
                stall_o    = 1'b1;
                noop_o     = 1'b1;
            end else begin
                flush_o    = branch_taken_id_i;
            end
        end
    end

    // A frozen pipeline keeps state and remaining count so the stall resumes intact
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else if (!mem_stall_i) begin
            case (r_state)
                IDLE: begin
                    if (w_hit && c_multi) begin
                        r_state <= LOAD_STALL;
                        r_rem   <= c_rem_init;
                    end
                end
                LOAD_STALL: begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == REM_W'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rem   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_load_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_load_stall_cnt <= '0;
            r_flush_cnt      <= '0;
        end else begin
            if (noop_o)  r_load_stall_cnt <= r_load_stall_cnt + 32'd1;
            if (flush_o) r_flush_cnt      <= r_flush_cnt + 32'd1;
        end
    end

    assign load_stall_cnt_o = r_load_stall_cnt;
    assign flush_cnt_o      = r_flush_cnt;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench; LOAD_LAT=1 and LOAD_LAT=3 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Output vector order: {pc_write, stall, noop, flush, freeze}
    localparam logic [4:0] c_def = 5'b10000;
    localparam logic [4:0] c_stl = 5'b01100;
    localparam logic [4:0] c_frz = 5'b01001;
    localparam logic [4:0] c_fls = 5'b10010;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rd_addr_ex;
    logic       mem_read_ex;
    logic [9:0] rs_addr_id;
    logic [1:0] rs_used_id;
    logic       branch_taken_id;
    logic       mem_stall;

    logic pc1, st1, np1, fl1, fz1;
    logic pc3, st3, np3, fl3, fz3;
    logic [4:0] o1, o3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    logic [31:0] lsc1, fc1, lsc3, fc3;
`endif

    hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1)) dut1 (
        .clk_i             (clk),
        .rst_i             (rst),
        .rd_addr_ex_i      (rd_addr_ex),
        .mem_read_ex_i     (mem_read_ex),
        .rs_addr_id_i      (rs_addr_id),
        .rs_used_id_i      (rs_used_id),
        .branch_taken_id_i (branch_taken_id),
        .mem_stall_i       (mem_stall),
        .pc_write_o        (pc1),
        .stall_o           (st1),
        .noop_o            (np1),
        .flush_o           (fl1),
        .freeze_o          (fz1)
`ifdef HAZARD_PERF_EN
        ,
        .load_stall_cnt_o  (lsc1),
        .flush_cnt_o       (fc1)
`endif
    );

    hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3)) dut3 (
        .clk_i             (clk),
        .rst_i             (rst),
        .rd_addr_ex_i      (rd_addr_ex),
        .mem_read_ex_i     (mem_read_ex),
        .rs_addr_id_i      (rs_addr_id),
        .rs_used_id_i      (rs_used_id),
        .branch_taken_id_i (branch_taken_id),
        .mem_stall_i       (mem_stall),
        .pc_write_o        (pc3),
        .stall_o           (st3),
        .noop_o            (np3),
        .flush_o           (fl3),
        .freeze_o          (fz3)
`ifdef HAZARD_PERF_EN
        ,
        .load_stall_cnt_o  (lsc3),
        .flush_cnt_o       (fc3)
`endif
    );

    assign o1 = {pc1, st1, np1, fl1, fz1};
    assign o3 = {pc3, st3, np3, fl3, fz3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge; outputs settle before the next rise
    task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic br, input logic ms);
        @(negedge clk);
        rst             = r;
        mem_read_ex     = mr;
        rd_addr_ex      = rd;
        rs_addr_id      = {s1, s0};
        rs_used_id      = used;
        branch_taken_id = br;
        mem_stall       = ms;
        #1;
    endtask

    task automatic both(input string tag, input logic [4:0] e1, input logic [4:0] e3);
        chk({tag, "_lat1"}, {27'd0, o1}, {27'd0, e1});
        chk({tag, "_lat3"}, {27'd0, o3}, {27'd0, e3});
    endtask

    initial begin
        rst = 1'b1; mem_read_ex = 1'b0; rd_addr_ex = '0; rs_addr_id = '0;
        rs_used_id = '0; branch_taken_id = 1'b0; mem_stall = 1'b0;

        // Reset overrides a live hit
        drive(1, 1, 5, 5, 0, 2'b01, 1, 0);  both("reset_hit", c_def, c_def);
        drive(1, 0, 0, 0, 0, 2'b00, 0, 0);  both("reset",     c_def, c_def);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("idle",      c_def, c_def);

        // rs1 load-use hit
        drive(0, 1, 5, 5, 0, 2'b01, 0, 0);  both("rs1_hit",   c_stl, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs1_c1",    c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs1_c2",    c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs1_c3",    c_def, c_def);

        // rs2-only hit
        drive(0, 1, 9, 3, 9, 2'b11, 0, 0);  both("rs2_hit",   c_stl, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs2_c1",    c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs2_c2",    c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rs2_c3",    c_def, c_def);

        // Non-hazards
        drive(0, 1, 0, 0, 0, 2'b11, 0, 0);  both("rd_zero",   c_def, c_def);
        drive(0, 1, 5, 5, 5, 2'b00, 0, 0);  both("unused",    c_def, c_def);
        drive(0, 1, 5, 7, 5, 2'b01, 0, 0);  both("unused_rs2",c_def, c_def);
        drive(0, 0, 5, 5, 5, 2'b11, 0, 0);  both("no_load",   c_def, c_def);

        // Freeze during the second stall cycle keeps the remaining count
        drive(0, 1, 6, 6, 0, 2'b01, 0, 0);  both("frz_hit",   c_stl, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 1);  both("frz_1",     c_frz, c_frz);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 1);  both("frz_2",     c_frz, c_frz);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("frz_res1",  c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("frz_res2",  c_def, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("frz_done",  c_def, c_def);

        // Branch waiting on a load operand flushes when its stall ends
        drive(0, 1, 7, 7, 0, 2'b01, 1, 0);  both("br_hit",    c_stl, c_stl);
        drive(0, 0, 0, 7, 0, 2'b01, 1, 0);  both("br_c1",     c_fls, c_stl);
        drive(0, 0, 0, 7, 0, 2'b01, 1, 0);  both("br_c2",     c_fls, c_stl);
        drive(0, 0, 0, 7, 0, 2'b01, 1, 0);  both("br_c3",     c_fls, c_fls);
        drive(0, 0, 0, 0, 0, 2'b00, 1, 1);  both("br_frz",    c_frz, c_frz);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("br_clr",    c_def, c_def);

        // Reset aborts an in-progress stall
        drive(0, 1, 4, 0, 4, 2'b10, 0, 0);  both("rst_hit",   c_stl, c_stl);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rst_c1",    c_def, c_stl);
        drive(1, 0, 0, 0, 0, 2'b00, 0, 0);  both("rst_mid",   c_def, c_def);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);  both("rst_after", c_def, c_def);
`ifdef HAZARD_PERF_EN
        chk("lsc1_rst", lsc1, 32'd0);
        chk("fc1_rst",  fc1,  32'd0);
        chk("lsc3_rst", lsc3, 32'd0);
        chk("fc3_rst",  fc3,  32'd0);
        drive(0, 1, 4, 4, 0, 2'b01, 0, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 1, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("lsc1_cnt", lsc1, 32'd1);
        chk("fc1_cnt",  fc1,  32'd1);
        chk("lsc3_cnt", lsc3, 32'd3);
        chk("fc3_cnt",  fc3,  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
